// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared types and constants for the serial shift transmitter.
//   tx_state_t    : transmitter FSM state encoding
//   DEFAULT_WIDTH : default word width in bits
// ---------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } tx_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : shift_pkg

// File: rtl/bit_counter.sv
// ---------------------------------------------------------------------------
// bit_counter
// Modulo-WIDTH bit counter that tracks which bit of a word is on the line.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (count -> 0)
//   i_clr   : synchronous clear (count -> 0), has priority over i_en
//   i_en    : advance count by one, wrapping from WIDTH-1 to 0
//   o_last  : count currently equals WIDTH-1
// ---------------------------------------------------------------------------
module bit_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST_CNT);
  assign o_last = w_last;

  // Count register: clear wins, otherwise wrap at WIDTH-1 so it never exceeds it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule : bit_counter

// File: rtl/piso_shift_tx.sv
// ---------------------------------------------------------------------------
// piso_shift_tx
// Parallel-in / serial-out transmitter. Takes a WIDTH-bit word over a
// valid/ready handshake and shifts it onto ssout one bit per shift_en tick.
// Back-to-back words are chained without an idle gap.
// Ports:
//   cc       : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   P        : parallel word to transmit
//   p_valid  : P holds a word to send
//   p_ready  : transmitter accepts P this cycle (combinational)
//   shift_en : bit tick; consumes the bit on ssout at the next edge
//   ssout    : serial data (registered)
//   sframe   : high while ssout carries a data bit (registered)
//   sdone    : one-cycle pulse after the last bit of a word is consumed
// ---------------------------------------------------------------------------
module piso_shift_tx
  import shift_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             cc,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] P,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic             shift_en,
  output logic             ssout,
  output logic             sframe,
  output logic             sdone
);

  tx_state_t        r_state;
  tx_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             r_ssout;
  logic             r_sframe;
  logic             r_sdone;
  logic             w_ssout_nxt;
  logic             w_sframe_nxt;
  logic             w_sdone_nxt;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_last;

  // Bit presented at the output end of a shift register image.
  function automatic logic out_bit(input logic [WIDTH-1:0] sh);
    if (MSB_FIRST) begin
      out_bit = sh[WIDTH-1];
    end else begin
      out_bit = sh[0];
    end
  endfunction

  // Move the shift register one place toward its output end.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] sh);
    if (MSB_FIRST) begin
      shift_once = {sh[WIDTH-2:0], 1'b0};
    end else begin
      shift_once = {1'b0, sh[WIDTH-1:1]};
    end
  endfunction

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .i_clk   (cc),
    .i_rst_n (rst_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_last  (w_last)
  );

  // Ready in idle, or on the edge that consumes the last bit so a new word
  // can be chained with no gap.
  assign p_ready = (r_state == S_IDLE) ||
                   ((r_state == S_SHIFT) && w_last && shift_en);

  // Next-state / next-data decode for the FSM and shift register.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_sdone_nxt = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (p_valid) begin
          w_shreg_nxt = P;
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (shift_en) begin
          if (w_last) begin
            w_sdone_nxt = 1'b1;
            w_cnt_clr   = 1'b1;
            if (p_valid) begin
              w_shreg_nxt = P;
              w_state_nxt = S_SHIFT;
            end else begin
              w_shreg_nxt = '0;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_en    = 1'b1;
            w_shreg_nxt = shift_once(r_shreg);
          end
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_shreg_nxt = '0;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  // Output values are computed from next state so ssout/sframe come straight
  // from flops and the first bit shows up the cycle after the handshake.
  always_comb begin
    w_sframe_nxt = 1'b0;
    w_ssout_nxt  = IDLE_LEVEL;
    if (w_state_nxt == S_SHIFT) begin
      w_sframe_nxt = 1'b1;
      w_ssout_nxt  = out_bit(w_shreg_nxt);
    end else begin
      w_sframe_nxt = 1'b0;
      w_ssout_nxt  = IDLE_LEVEL;
    end
  end

  // State, shift register and registered outputs; reset aborts any frame.
  always_ff @(posedge cc or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_ssout  <= IDLE_LEVEL;
      r_sframe <= 1'b0;
      r_sdone  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_ssout  <= w_ssout_nxt;
      r_sframe <= w_sframe_nxt;
      r_sdone  <= w_sdone_nxt;
    end
  end

  assign ssout  = r_ssout;
  assign sframe = r_sframe;
  assign sdone  = r_sdone;

endmodule : piso_shift_tx

// File: tb/tb_piso_shift_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_shift_tx
// Scoreboard bench: stimulus pushes hand-written expected bit sequences into
// per-instance queues; negedge monitors pop and compare every consumed bit.
// Instance A: WIDTH=8, LSB first, idle 0. Instance B: MSB first, idle 1.
// ---------------------------------------------------------------------------
module tb_piso_shift_tx;

  logic       cc = 1'b0;
  logic       rst_n;
  logic [7:0] p_a, p_b;
  logic       pv_a, pv_b, pr_a, pr_b, se_a, se_b;
  logic       so_a, so_b, sf_a, sf_b, sd_a, sd_b;

  int n_checks = 0;
  int n_fail   = 0;

  bit exp_a[$];
  bit exp_b[$];

  int   sframe_cnt_a = 0, sdone_cnt_a = 0, drops_a = 0;
  int   sframe_cnt_b = 0, sdone_cnt_b = 0;
  logic prev_sf_a = 1'b0;
  logic [7:0] rx = 8'h00;

  always #5 cc = ~cc;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut_a (
    .cc(cc), .rst_n(rst_n), .P(p_a), .p_valid(pv_a), .p_ready(pr_a),
    .shift_en(se_a), .ssout(so_a), .sframe(sf_a), .sdone(sd_a)
  );

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_dut_b (
    .cc(cc), .rst_n(rst_n), .P(p_b), .p_valid(pv_b), .p_ready(pr_b),
    .shift_en(se_b), .ssout(so_b), .sframe(sf_b), .sdone(sd_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Receiver model: LSB-first serial-in shift register fed by instance A.
  always @(posedge cc) begin
    if (sf_a && se_a) rx <= {so_a, rx[7:1]};
  end

  // Monitor A: compare each consumed bit against the scoreboard.
  always @(negedge cc) begin : mon_a
    bit e;
    if (rst_n) begin
      if (sf_a) begin
        sframe_cnt_a++;
        if (se_a) begin
          if (exp_a.size() == 0) begin
            check("a_unexpected_bit", 32'd1, 32'd0);
          end else begin
            e = exp_a.pop_front();
            check("a_ssout", {31'd0, so_a}, {31'd0, e});
          end
        end
      end else begin
        check("a_idle_level", {31'd0, so_a}, 32'd0);
      end
      if (prev_sf_a && !sf_a) drops_a++;
      if (sd_a) sdone_cnt_a++;
    end
    prev_sf_a = sf_a;
  end

  // Monitor B: same scoreboard check for the MSB-first, idle-high instance.
  always @(negedge cc) begin : mon_b
    bit e;
    if (rst_n) begin
      if (sf_b) begin
        sframe_cnt_b++;
        if (se_b) begin
          if (exp_b.size() == 0) begin
            check("b_unexpected_bit", 32'd1, 32'd0);
          end else begin
            e = exp_b.pop_front();
            check("b_ssout", {31'd0, so_b}, {31'd0, e});
          end
        end
      end else begin
        check("b_idle_level", {31'd0, so_b}, 32'd1);
      end
      if (sd_b) sdone_cnt_b++;
    end
  end

  // seq lists bits first-sent at the left (bit n-1) to last-sent at bit 0.
  task automatic push_exp(input bit sel, input logic [15:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (sel) exp_b.push_back(seq[i]);
      else     exp_a.push_back(seq[i]);
    end
  endtask

  task automatic clear_counts();
    sframe_cnt_a = 0; sdone_cnt_a = 0; drops_a = 0;
    sframe_cnt_b = 0; sdone_cnt_b = 0;
  endtask

  // Present a word and hold it until the handshake edge (bounded wait).
  task automatic send(input bit sel, input logic [7:0] w, input bit keep_valid);
    bit took = 1'b0;
    if (sel) begin p_b = w; pv_b = 1'b1; end
    else     begin p_a = w; pv_a = 1'b1; end
    for (int i = 0; i < 20 && !took; i++) begin
      @(negedge cc);
      took = sel ? pr_b : pr_a;
      @(posedge cc); #1;
    end
    check(sel ? "b_handshake" : "a_handshake", {31'd0, took}, 32'd1);
    if (!keep_valid) begin
      if (sel) pv_b = 1'b0;
      else     pv_a = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    p_a = 8'h00; p_b = 8'h00; pv_a = 1'b0; pv_b = 1'b0; se_a = 1'b0; se_b = 1'b0;
    repeat (2) @(posedge cc); #1;
    check("rst_ready_a",  {31'd0, pr_a}, 32'd1);
    check("rst_ssout_a",  {31'd0, so_a}, 32'd0);
    check("rst_sframe_a", {31'd0, sf_a}, 32'd0);
    check("rst_sdone_a",  {31'd0, sd_a}, 32'd0);
    check("rst_ssout_b",  {31'd0, so_b}, 32'd1);
    check("rst_ready_b",  {31'd0, pr_b}, 32'd1);
    rst_n = 1'b1;
    @(posedge cc); #1;

    // Single word 0xA3 with continuous ticks: bits 1,1,0,0,0,1,0,1.
    clear_counts();
    se_a = 1'b1;
    push_exp(1'b0, 16'b1100_0101, 8);
    send(1'b0, 8'hA3, 1'b0);
    repeat (12) @(posedge cc); #1;
    check("t2_sframe_cycles", sframe_cnt_a, 32'd8);
    check("t2_sdone_pulses",  sdone_cnt_a,  32'd1);
    check("t2_ready_back",    {31'd0, pr_a}, 32'd1);
    check("t2_queue_empty",   exp_a.size(), 32'd0);

    // Loopback into the receiver model.
    clear_counts();
    rx = 8'h00;
    push_exp(1'b0, 16'b1010_0101, 8);
    send(1'b0, 8'hA5, 1'b0);
    repeat (12) @(posedge cc); #1;
    check("t3_rx_word",      {24'd0, rx}, 32'h0000_00A5);
    check("t3_sdone_pulses", sdone_cnt_a, 32'd1);

    // Back-to-back 0xFF then 0x00, valid held: 16 framed bits, no gap.
    clear_counts();
    push_exp(1'b0, 16'hFF00, 16);
    send(1'b0, 8'hFF, 1'b1);
    send(1'b0, 8'h00, 1'b0);
    repeat (12) @(posedge cc); #1;
    check("t4_sframe_cycles", sframe_cnt_a, 32'd16);
    check("t4_sdone_pulses",  sdone_cnt_a,  32'd2);
    check("t4_sframe_drops",  drops_a,      32'd1);
    check("t4_queue_empty",   exp_a.size(), 32'd0);

    // Tick every third cycle, P disturbed mid-frame: 0x81 -> 1,0,0,0,0,0,0,1.
    clear_counts();
    se_a = 1'b0;
    push_exp(1'b0, 16'b1000_0001, 8);
    send(1'b0, 8'h81, 1'b0);
    for (int i = 0; i < 27; i++) begin
      se_a = (i % 3 == 2);
      if (i == 7) p_a = 8'h3C;
      @(posedge cc); #1;
    end
    se_a = 1'b0;
    repeat (3) @(posedge cc); #1;
    check("t5_sframe_cycles", sframe_cnt_a, 32'd24);
    check("t5_sdone_pulses",  sdone_cnt_a,  32'd1);
    check("t5_queue_empty",   exp_a.size(), 32'd0);

    // Asynchronous reset mid-frame on instance A.
    clear_counts();
    se_a = 1'b1;
    push_exp(1'b0, 16'b1100_0101, 8);
    send(1'b0, 8'hA3, 1'b0);
    repeat (3) @(posedge cc);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_ssout",  {31'd0, so_a}, 32'd0);
    check("t1_rst_sframe", {31'd0, sf_a}, 32'd0);
    check("t1_rst_sdone",  {31'd0, sd_a}, 32'd0);
    check("t1_rst_ready",  {31'd0, pr_a}, 32'd1);
    exp_a.delete();
    @(posedge cc); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge cc); #1;
    check("t1_no_sdone", sdone_cnt_a, 32'd0);

    // MSB first, idle high: 0xC0 -> 1,1,0,0,0,0,0,0.
    clear_counts();
    se_b = 1'b1;
    check("t6_line_before", {31'd0, so_b}, 32'd1);
    push_exp(1'b1, 16'b1100_0000, 8);
    send(1'b1, 8'hC0, 1'b0);
    repeat (12) @(posedge cc); #1;
    check("t6_sframe_cycles", sframe_cnt_b, 32'd8);
    check("t6_sdone_pulses",  sdone_cnt_b,  32'd1);
    check("t6_line_after",    {31'd0, so_b}, 32'd1);
    check("t6_queue_empty",   exp_b.size(), 32'd0);

    // Reset after the third bit of a second 0xC0 frame.
    clear_counts();
    push_exp(1'b1, 16'b1100_0000, 8);
    send(1'b1, 8'hC0, 1'b0);
    repeat (3) @(posedge cc);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ssout",  {31'd0, so_b}, 32'd1);
    check("t6_rst_sframe", {31'd0, sf_b}, 32'd0);
    check("t6_rst_sdone",  {31'd0, sd_b}, 32'd0);
    check("t6_rst_ready",  {31'd0, pr_b}, 32'd1);
    exp_b.delete();
    @(posedge cc); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge cc); #1;
    check("t6_no_sdone",   sdone_cnt_b, 32'd0);
    check("t6_line_idle",  {31'd0, so_b}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_piso_shift_tx
